// File: rtl/prsc_tile_transposer.sv
// Ping-pong tile transposer: captures columns into a TILE_SIZE x TILE_SIZE bank and streams rows.
// Optional build macro PRSC_RELU_CLIP_EN clamps negative (MSB-set) pixels to zero at capture.
module prsc_tile_transposer #(
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned TILE_SIZE = 6
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           col_valid_i,
    input  logic [PIX_WIDTH*TILE_SIZE-1:0] col_data_i,
    output logic                           row_valid_o,
    input  logic                           row_ready_i,
    output logic [PIX_WIDTH*TILE_SIZE-1:0] row_data_o,
    output logic                           row_last_o,
    output logic                           tile_done_o,
    output logic                           overflow_o
);

    localparam int unsigned COL_W = PIX_WIDTH * TILE_SIZE;
    localparam int unsigned PTR_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TILE_SIZE - 1);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic [1:0]       bank_state_q [2];
    logic [1:0]       bank_state_d [2];
    logic [COL_W-1:0] mem_q [2][TILE_SIZE];

    logic             wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0] wr_col_q, wr_col_d;
    logic             rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0] rd_row_q, rd_row_d;
    logic             tile_done_q;
    logic             overflow_q;

    logic             wr_open;
    logic             col_take;
    logic             col_drop;
    logic             row_fire;
    logic [COL_W-1:0] col_in;

    assign wr_open  = (bank_state_q[wr_bank_q] == ST_EMPTY) ||
                      (bank_state_q[wr_bank_q] == ST_FILLING);
    assign col_take = en_i && col_valid_i && wr_open;
    assign col_drop = en_i && col_valid_i && !wr_open;

    assign row_valid_o = (bank_state_q[rd_bank_q] == ST_FULL) ||
                         (bank_state_q[rd_bank_q] == ST_DRAINING);
    assign row_fire    = row_valid_o && row_ready_i;
    assign row_last_o  = row_valid_o && (rd_row_q == LAST_IDX);
    assign tile_done_o = tile_done_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        col_in = col_data_i;
`ifdef PRSC_RELU_CLIP_EN
        for (int r = 0; r < TILE_SIZE; r++) begin
            if (col_data_i[r*PIX_WIDTH+PIX_WIDTH-1]) begin
                col_in[r*PIX_WIDTH+:PIX_WIDTH] = '0;
            end
        end
`else
        col_in = col_data_i;
`endif
    end

    // Transposed view: output pixel c is pixel rd_row of stored column c; zero when idle.
    always_comb begin
        row_data_o = '0;
        if (row_valid_o) begin
            for (int c = 0; c < TILE_SIZE; c++) begin
                row_data_o[c*PIX_WIDTH+:PIX_WIDTH] =
                    mem_q[rd_bank_q][c][rd_row_q*PIX_WIDTH+:PIX_WIDTH];
            end
        end
    end

    // Write and read never target the same bank: their state preconditions are disjoint.
    always_comb begin
        bank_state_d[0] = bank_state_q[0];
        bank_state_d[1] = bank_state_q[1];
        wr_bank_d       = wr_bank_q;
        wr_col_d        = wr_col_q;
        rd_bank_d       = rd_bank_q;
        rd_row_d        = rd_row_q;
        if (col_take) begin
            if (wr_col_q == LAST_IDX) begin
                bank_state_d[wr_bank_q] = ST_FULL;
                wr_col_d                = '0;
                wr_bank_d               = ~wr_bank_q;
            end else begin
                bank_state_d[wr_bank_q] = ST_FILLING;
                wr_col_d                = wr_col_q + 1'b1;
            end
        end
        if (row_fire) begin
            if (rd_row_q == LAST_IDX) begin
                bank_state_d[rd_bank_q] = ST_EMPTY;
                rd_row_d                = '0;
                rd_bank_d               = ~rd_bank_q;
            end else begin
                bank_state_d[rd_bank_q] = ST_DRAINING;
                rd_row_d                = rd_row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_state_q[0] <= ST_EMPTY;
            bank_state_q[1] <= ST_EMPTY;
            wr_bank_q       <= 1'b0;
            wr_col_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_row_q        <= '0;
            tile_done_q     <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            bank_state_q[0] <= bank_state_d[0];
            bank_state_q[1] <= bank_state_d[1];
            wr_bank_q       <= wr_bank_d;
            wr_col_q        <= wr_col_d;
            rd_bank_q       <= rd_bank_d;
            rd_row_q        <= rd_row_d;
            tile_done_q     <= row_fire && (rd_row_q == LAST_IDX);
            overflow_q      <= overflow_q || col_drop;
        end
    end

    // Pixel storage needs no reset: contents are only visible while a bank is FULL/DRAINING.
    always_ff @(posedge clk_i) begin
        if (col_take) begin
            mem_q[wr_bank_q][wr_col_q] <= col_in;
        end
    end

endmodule

// File: tb/tb_prsc_tile_transposer.sv
// Directed + randomized bench for prsc_tile_transposer against a queue-based tile model.
module tb_prsc_tile_transposer;

    localparam int P = 8;
    localparam int T = 6;
    localparam int W = P * T;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         col_valid;
    logic [W-1:0] col_data;
    logic         row_valid;
    logic         row_ready;
    logic [W-1:0] row_data;
    logic         row_last;
    logic         tile_done;
    logic         overflow;

    prsc_tile_transposer #(
        .PIX_WIDTH(P),
        .TILE_SIZE(T)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .col_valid_i(col_valid),
        .col_data_i (col_data),
        .row_valid_o(row_valid),
        .row_ready_i(row_ready),
        .row_data_o (row_data),
        .row_last_o (row_last),
        .tile_done_o(tile_done),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: every accepted, not yet drained column in arrival order; each 6 form a tile.
    logic [W-1:0] cols[$];
    int           rd_exp   = 0;
    bit           done_exp = 1'b0;
    bit           ovf_exp  = 1'b0;

    function automatic logic [W-1:0] stored(input logic [W-1:0] c);
        logic [W-1:0] s;
        s = c;
`ifdef PRSC_RELU_CLIP_EN
        for (int r = 0; r < T; r++) begin
            if (c[r*P+P-1]) s[r*P+:P] = '0;
        end
`endif
        return s;
    endfunction

    function automatic logic [W-1:0] rand_col();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] cc;
        v = (cols.size() >= T);
        d = '0;
        if (v) begin
            for (int c = 0; c < T; c++) begin
                cc = cols[c];
                d[c*P+:P] = cc[rd_exp*P+:P];
            end
        end
        chk("row_valid", W'(row_valid), W'(v));
        chk("row_data", row_data, d);
        chk("row_last", W'(row_last), W'(v && (rd_exp == T - 1)));
        chk("tile_done", W'(tile_done), W'(done_exp));
        chk("overflow", W'(overflow), W'(ovf_exp));
    endtask

    // Called at a negedge: check current outputs, drive inputs, advance model one clock.
    task automatic cycle(input bit e, input bit v, input bit rdy, input logic [W-1:0] d);
        bit accept;
        bit fire;
        check_outputs();
        en        = e;
        col_valid = v;
        row_ready = rdy;
        col_data  = d;
        accept    = e && v && (cols.size() / T < 2);
        fire      = (cols.size() >= T) && rdy;
        done_exp  = 1'b0;
        if (fire) begin
            rd_exp++;
            if (rd_exp == T) begin
                for (int i = 0; i < T; i++) void'(cols.pop_front());
                rd_exp   = 0;
                done_exp = 1'b1;
            end
        end
        if (accept) cols.push_back(stored(d));
        if (e && v && !accept) ovf_exp = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, rdy, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before the next edge.
    task automatic do_reset();
        #2;
        rst       = 1'b1;
        en        = 1'b0;
        col_valid = 1'b0;
        row_ready = 1'b0;
        cols.delete();
        rd_exp   = 0;
        done_exp = 1'b0;
        ovf_exp  = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] c;
        logic [W-1:0] exp_row;
        logic [7:0]   p;

        rst       = 1'b1;
        en        = 1'b0;
        col_valid = 1'b0;
        row_ready = 1'b0;
        col_data  = '0;
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single tile with known pixels.
        for (int k = 0; k < T; k++) begin
            for (int r = 0; r < T; r++) c[r*P+:P] = 8'(10 * k + r);
            cycle(1'b1, 1'b1, 1'b1, c);
        end
        for (int col = 0; col < T; col++) exp_row[col*P+:P] = 8'(10 * col);
        chk("t1_row0_const", row_data, exp_row);
        chk("t1_valid_latency", W'(row_valid), W'(1));
        idle(8, 1'b1);

        // Back-to-back tiles.
        for (int k = 0; k < 2 * T; k++) cycle(1'b1, 1'b1, 1'b1, rand_col());
        idle(10, 1'b1);
        chk("t2_no_overflow", W'(overflow), W'(0));

        // Backpressure held on row 2.
        for (int k = 0; k < T; k++) cycle(1'b1, 1'b1, 1'b1, rand_col());
        idle(2, 1'b1);
        idle(10, 1'b0);
        idle(8, 1'b1);

        // Overflow: 13 columns with no draining.
        for (int k = 0; k < 2 * T + 1; k++) cycle(1'b1, 1'b1, 1'b0, rand_col());
        chk("t4_overflow_set", W'(overflow), W'(1));
        idle(2 * T + 3, 1'b1);

        // Reset while tile 1 drains and tile 2 is partly filled.
        do_reset();
        for (int k = 0; k < T + 3; k++) cycle(1'b1, 1'b1, 1'b1, rand_col());
        do_reset();
        chk("t5_valid_after_rst", W'(row_valid), W'(0));
        for (int k = 0; k < T; k++) cycle(1'b1, 1'b1, 1'b1, rand_col());
        idle(8, 1'b1);

        // Negative / positive pixel handling.
        c = rand_col();
        c[7:0]  = 8'hF0;
        c[15:8] = 8'h7F;
        cycle(1'b1, 1'b1, 1'b0, c);
        for (int k = 1; k < T; k++) cycle(1'b1, 1'b1, 1'b0, rand_col());
`ifdef PRSC_RELU_CLIP_EN
        p = 8'h00;
`else
        p = 8'hF0;
`endif
        chk("t6_pix_f0", W'(row_data[7:0]), W'(p));
        cycle(1'b1, 1'b0, 1'b1, '0);
        chk("t6_pix_7f", W'(row_data[7:0]), W'(8'h7F));
        idle(8, 1'b1);

        // Random traffic, including en_i low and random backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 6), rand_col());
        end
        idle(20, 1'b1);
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 8), rand_col());
        end
        idle(20, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
